// File: rtl/systolic_array_ctrl.sv
// Sequencer for a SIZE x SIZE weight-stationary systolic array.
// A pass runs in this order:
//   1. Preload one weight tile, streaming the rows bottom row first.
//   2. Stream N activation vectors.
//   3. Wait out the drain latency through the array.
// A single shift register, fed by the activation read strobe, produces both
// the per-row skew enables and the per-column result-valid strobes.
module systolic_array_ctrl #(
    parameter int SIZE     = 8,
    parameter int ROW_W    = 8,
    parameter int W_ADDR_W = $clog2(SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ROW_W-1:0]    num_vec,
    output logic                busy,
    output logic                done,
    output logic                w_rd_en,
    output logic [W_ADDR_W-1:0] w_addr,
    output logic                weight_valid,
    output logic                a_rd_en,
    output logic [ROW_W-1:0]    a_addr,
    output logic [SIZE-1:0]     lane_en,
    output logic [SIZE-1:0]     col_valid
);

    localparam int CNT_W = $clog2(2 * SIZE) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [ROW_W-1:0]  vec_cnt_q, vec_cnt_d;
    logic [ROW_W-1:0]  num_q, num_d;
    logic              wv_q;
    // Bit k carries a_rd_en delayed by k+1 cycles.
    logic [2*SIZE-1:0] dly_q;

    // State, counters and the captured vector count.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            load_cnt_q  <= '0;
            drain_cnt_q <= '0;
            vec_cnt_q   <= '0;
            num_q       <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            num_q       <= num_d;
        end
    end

    // Next-state logic and per-phase counters.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        drain_cnt_d = drain_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        num_d       = num_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d       = num_vec;
                    load_cnt_d  = '0;
                    drain_cnt_d = '0;
                    vec_cnt_d   = '0;
                    // An empty pass skips every buffer read and completes at once.
                    state_d     = (num_vec == '0) ? S_DONE : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (load_cnt_q == CNT_W'(SIZE - 1)) begin
                    load_cnt_d = '0;
                    state_d    = S_COMPUTE;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            S_COMPUTE: begin
                // The exit test lets N = 2^ROW_W-1 finish without wrapping a_addr.
                if (vec_cnt_q == num_q - ROW_W'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    vec_cnt_d = vec_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == CNT_W'(2 * SIZE - 1)) begin
                    drain_cnt_d = '0;
                    state_d     = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Weight-valid follows the weight read by one cycle, in step with buffer latency.
    // The skew and column-valid line shifts in every state; only rst clears it.
    always_ff @(posedge clk) begin
        // NOTE: the delay line is reset, so no stale strobe survives an aborted pass.
        if (rst) begin
            wv_q  <= 1'b0;
            dly_q <= '0;
        end else begin
            wv_q  <= w_rd_en;
            dly_q <= {dly_q[2*SIZE-2:0], a_rd_en};
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign w_rd_en      = (state_q == S_LOAD_W);
    // Bottom row first: rows already loaded shift down as each new row enters.
    assign w_addr       = w_rd_en ? W_ADDR_W'(SIZE - 1 - int'(load_cnt_q)) : '0;
    assign weight_valid = wv_q;
    assign a_rd_en      = (state_q == S_COMPUTE);
    assign a_addr       = a_rd_en ? vec_cnt_q : '0;
    assign lane_en      = dly_q[SIZE-1:0];
    assign col_valid    = dly_q[2*SIZE-1:SIZE];

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl.
// Expected strobes for each cycle come from the start cycle and N of the
// current pass, using plain arithmetic. A behavioural 8x8 PE array, driven
// by the controller's strobes, must reproduce a golden matrix product.
module tb_systolic_array_ctrl;

    localparam int SIZE = 8;
    localparam int ROW_W = 8;
    localparam int WAW = $clog2(SIZE);
    localparam int MAXC = 4096;

    logic             clk, rst, start;
    logic [ROW_W-1:0] num_vec;
    logic             busy, done, w_rd_en, weight_valid, a_rd_en;
    logic [WAW-1:0]   w_addr;
    logic [ROW_W-1:0] a_addr;
    logic [SIZE-1:0]  lane_en, col_valid;

    systolic_array_ctrl #(.SIZE(SIZE), .ROW_W(ROW_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
        .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_addr(w_addr),
        .weight_valid(weight_valid), .a_rd_en(a_rd_en), .a_addr(a_addr),
        .lane_en(lane_en), .col_valid(col_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffers and the behavioural PE array.
    logic signed [7:0] wmem [SIZE][SIZE];
    logic signed [7:0] amem [256][SIZE];
    logic signed [7:0] w_data_q [SIZE];
    logic signed [7:0] a_data_q [SIZE];
    logic signed [7:0] skew_q [SIZE][SIZE];
    int                w_q [SIZE][SIZE];
    int                act_q [SIZE][SIZE];
    int                psum_q [SIZE][SIZE];
    int                act_in [SIZE];

    // Left-edge activation for each row: skewed data, gated by the lane enable.
    always_comb begin
        for (int r = 0; r < SIZE; r++) begin
            act_in[r] = 0;
            if (lane_en[r]) act_in[r] = (r == 0) ? int'(a_data_q[0]) : int'(skew_q[r][r]);
        end
    end

    // Buffer reads, skew pipeline, weight shift chain and the PE grid.
    always @(posedge clk) begin
        for (int c = 0; c < SIZE; c++) begin
            if (w_rd_en) w_data_q[c] <= wmem[w_addr][c];
            if (a_rd_en) a_data_q[c] <= amem[a_addr][c];
            skew_q[1][c] <= a_data_q[c];
            for (int r = 2; r < SIZE; r++) skew_q[r][c] <= skew_q[r-1][c];
        end
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                if (weight_valid) begin
                    if (r == 0) w_q[r][c] <= int'(w_data_q[c]);
                    else        w_q[r][c] <= w_q[r-1][c];
                end
                if (c == 0) begin
                    act_q[r][c] <= act_in[r];
                    if (r == 0) psum_q[r][c] <= w_q[r][c] * act_in[r];
                    else        psum_q[r][c] <= psum_q[r-1][c] + w_q[r][c] * act_in[r];
                end else begin
                    act_q[r][c] <= act_q[r][c-1];
                    if (r == 0) psum_q[r][c] <= w_q[r][c] * act_q[r][c-1];
                    else        psum_q[r][c] <= psum_q[r-1][c] + w_q[r][c] * act_q[r][c-1];
                end
            end
        end
    end

    // Reference model state.
    int checks, errors;
    int t;          // current cycle number
    int ps, pn, pend;
    int rst_floor;  // last cycle rst was sampled; older strobes are flushed
    bit hist [MAXC];
    int res_idx [SIZE];

    function automatic int golden(input int v, input int c);
        int s = 0;
        for (int r = 0; r < SIZE; r++) s += int'(amem[v][r]) * int'(wmem[r][c]);
        return s;
    endfunction

    task automatic fill(input bit corner);
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                wmem[r][c] = corner ? -8'sd128 : 8'($urandom_range(0, 255));
        for (int v = 0; v < 256; v++)
            for (int r = 0; r < SIZE; r++)
                amem[v][r] = corner ? -8'sd128 : 8'($urandom_range(0, 255));
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    // Compare every output in cycle t against the current pass's timing rules.
    task automatic check_cycle();
        logic ebusy, edone, ew, ewv, ea;
        int eaddr, eaaddr, k, u;
        logic [SIZE-1:0] elane, ecol;
        ebusy = 0; edone = 0; ew = 0; ewv = 0; ea = 0; eaddr = 0; eaaddr = 0;
        if (ps >= 0 && t > ps && t <= pend) begin
            ebusy = 1;
            edone = (t == pend);
            if (pn > 0) begin
                k      = t - ps - 1;
                ew     = (k < SIZE);
                eaddr  = SIZE - 1 - k;
                ewv    = (t >= ps + 2) && (t <= ps + SIZE + 1);
                ea     = (k >= SIZE) && (k < SIZE + pn);
                eaaddr = k - SIZE;
            end
        end
        hist[t] = ea;
        for (int i = 0; i < SIZE; i++) begin
            u = t - 1 - i;
            elane[i] = (u >= 0) && (u > rst_floor) && hist[u];
            u = t - SIZE - 1 - i;
            ecol[i]  = (u >= 0) && (u > rst_floor) && hist[u];
        end
        chk("busy", 32'(busy), 32'(ebusy));
        chk("done", 32'(done), 32'(edone));
        chk("w_rd_en", 32'(w_rd_en), 32'(ew));
        if (ew) chk("w_addr", 32'(w_addr), 32'(eaddr));
        chk("weight_valid", 32'(weight_valid), 32'(ewv));
        chk("a_rd_en", 32'(a_rd_en), 32'(ea));
        if (ea) chk("a_addr", 32'(a_addr), 32'(eaaddr));
        chk("lane_en", 32'(lane_en), 32'(elane));
        chk("col_valid", 32'(col_valid), 32'(ecol));
        for (int j = 0; j < SIZE; j++) begin
            if (ecol[j] && res_idx[j] < 256) begin
                chk($sformatf("result col%0d vec%0d", j, res_idx[j]),
                    psum_q[SIZE-1][j], golden(res_idx[j], j));
                res_idx[j]++;
            end
        end
    endtask

    // Drive one cycle's inputs, update the model, advance, then check the next cycle.
    task automatic tick(input bit st, input int nv, input bit r);
        start   = st;
        num_vec = ROW_W'(nv);
        rst     = r;
        if (r) begin
            ps        = -1;
            rst_floor = t;
        end else if (st && (ps < 0 || t > pend)) begin
            ps   = t;
            pn   = nv;
            pend = (nv == 0) ? t + 1 : t + 3 * SIZE + nv + 1;
            for (int j = 0; j < SIZE; j++) res_idx[j] = 0;
        end
        @(posedge clk);
        #1;
        t++;
        check_cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; t = 0;
        ps = -1; pn = 0; pend = -1; rst_floor = 0;
        rst = 1'b1; start = 1'b0; num_vec = '0;
        for (int j = 0; j < SIZE; j++) res_idx[j] = 0;
        fill(0);
        #1;
        // Reset, then confirm everything is quiet.
        repeat (3) tick(0, 0, 1);
        idle(2);

        // N=4 directed pass.
        fill(0);
        tick(1, 4, 0);
        idle(3 * SIZE + 4 + 2);

        // N=1 pass: single-pulse skew and column strobes.
        fill(0);
        tick(1, 1, 0);
        idle(3 * SIZE + 1 + 2);

        // Empty pass: done the next cycle, no reads.
        tick(1, 0, 0);
        idle(3);

        // start held high; num_vec moves to 9 mid-pass; back-to-back second pass.
        fill(0);
        tick(1, 4, 0);
        repeat (2) tick(1, 4, 0);
        repeat (28) tick(1, 9, 0);
        idle(3 * SIZE + 9 + 2);

        // Reset mid-COMPUTE aborts the pass; a following start runs cleanly.
        fill(0);
        tick(1, 4, 0);
        idle(10);
        tick(0, 0, 1);
        idle(1);
        fill(0);
        tick(1, 4, 0);
        idle(3 * SIZE + 4 + 2);

        // Random-length passes with random data.
        repeat (4) begin
            n = $urandom_range(1, 20);
            fill(0);
            tick(1, n, 0);
            idle(3 * SIZE + n + 1 + $urandom_range(1, 3));
        end

        // Longest pass: N = 255.
        fill(0);
        tick(1, 255, 0);
        idle(3 * SIZE + 255 + 2);

        // Corner values: -128 * -128 everywhere.
        fill(1);
        tick(1, 3, 0);
        idle(3 * SIZE + 3 + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
Sequencer for a SIZE x SIZE weight-stationary systolic array of signed 8-bit PEs. On start it does three things in order:
- Preloads one weight tile by streaming SIZE rows down the array with the weight-valid strobe.
- Streams N activation vectors from the activation buffer and generates the per-row skew enables.
- Tracks drain latency, then generates per-column output-valid strobes for the result collector.

It sits between the layer scheduler (start/done) and the weight buffer, activation buffer, PE array and output collector.

Parameters:
SIZE, 8, array dimension (rows = columns = SIZE); minimum 2
ROW_W, 8, width of the activation-vector count and activation address
W_ADDR_W, $clog2(SIZE), width of the weight-buffer row address

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request one tile pass; sampled only in IDLE
num_vec  in  ROW_W  number of activation vectors N; sampled with start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the pass completes
w_rd_en  out  1  weight-buffer read strobe; read data valid 1 cycle later
w_addr  out  W_ADDR_W  weight-buffer row address
weight_valid  out  1  drives Weight_in_valid of every PE in the array
a_rd_en  out  1  activation-buffer read strobe; read data valid 1 cycle later
a_addr  out  ROW_W  activation-buffer vector address
lane_en  out  SIZE  per-array-row activation skew enable
col_valid  out  SIZE  per-column result valid at the bottom of the array

Behaviour:
- Reset (synchronous): state IDLE; all outputs and counters 0.
  - rst asserted mid-pass aborts the pass.
  - All strobes are 0 on the cycle after rst is sampled.
  - No done pulse is issued for an aborted pass.
- States:
  - IDLE -> LOAD_W when start=1 and num_vec!=0.
  - IDLE -> DONE when start=1 and num_vec=0; no buffer reads are issued in this case.
  - LOAD_W -> COMPUTE after exactly SIZE cycles.
  - COMPUTE -> DRAIN after exactly N cycles.
  - DRAIN -> DONE after exactly 2*SIZE cycles.
  - DONE -> IDLE after 1 cycle.
- start is ignored when not in IDLE. num_vec is captured into an internal register at start; later changes to num_vec have no effect on the pass.
- LOAD_W, cycle k = 0..SIZE-1:
  - w_rd_en=1 and w_addr=SIZE-1-k, so the bottom row is fetched first because weights shift downward.
  - weight_valid is w_rd_en registered once, so it is high for exactly SIZE consecutive cycles.
- COMPUTE, cycle k = 0..N-1: a_rd_en=1 and a_addr=k.
  - weight_valid is guaranteed 0 before the first activation reaches row 0, so PE psum/activation registers update only after the weights are frozen.
- Skew: lane_en[i] = a_rd_en delayed (1+i) cycles, i = 0..SIZE-1. Implement it as a shift register; no per-lane counters.
- Output: col_valid[j] = a_rd_en delayed (SIZE+1+j) cycles, j = 0..SIZE-1.
  - Each column is asserted for exactly N cycles.
  - The last col_valid[SIZE-1] pulse falls in the final DRAIN cycle.
- The delay lines keep shifting in every state and are cleared only by rst.
- done=1 only in DONE. busy=0 in IDLE and 1 in all other states.
- Timing when start is sampled at cycle 0 with N>0:
  - w_rd_en high in cycles 1..SIZE.
  - weight_valid high in cycles 2..SIZE+1.
  - a_rd_en high in cycles SIZE+1..SIZE+N.
  - done at cycle 3*SIZE+N+1.
  - A new start is accepted at cycle 3*SIZE+N+2 at the earliest.
- Counters:
  - The load counter and drain counter are sized $clog2(2*SIZE)+1.
  - The vector counter is ROW_W bits. N = 2^ROW_W-1 must run with no wrap of a_addr before the final value.
- No backpressure: the buffers and collector are required to accept every strobe.

Test Plan:
- SIZE=8, start at cycle 0, N=4:
  - w_addr sequence 7,6,...,0 in cycles 1..8.
  - weight_valid high in cycles 2..9.
  - a_addr 0..3 in cycles 9..12.
  - col_valid[0] high in cycles 18..21; col_valid[7] high in cycles 25..28.
  - done in cycle 29 only.
- N=1: lane_en[i] is a single pulse at cycle 10+i; every col_valid[j] is a single pulse; done at cycle 26.
- start with num_vec=0: done pulses in cycle 1; w_rd_en and a_rd_en stay 0; busy high for 1 cycle.
- start held high for the whole pass with num_vec changing to 9 in cycle 3: the pass still uses N=4; a second pass begins in cycle 30.
- rst asserted in cycle 11 (mid-COMPUTE): from cycle 12 all outputs are 0 and there is no done pulse; a start in cycle 13 produces a clean full pass.
- Reference model: a bench array of 8x8 PEs is driven by the controller against a golden matrix multiply, using random signed weights/activations, N=255, and -128*-128 corner values. All outputs must match.
